// File: rtl/riscv_pkg.sv
// Shared types and constants for the data-memory response path of the pipeline.
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    localparam int DMEM_WAIT_DEFAULT  = 2;
    localparam int DMEM_DEPTH_DEFAULT = 1024;

    // Index width for a word array, kept at least 1 so tiny memories still elaborate.
    function automatic int dmem_idx_width(input int depth_words);
        return (depth_words > 1) ? $clog2(depth_words) : 1;
    endfunction

endpackage

// File: rtl/dmem_resp_if.sv
// Memory-stage request/response bus between the pipeline (master) and data memory (slave).
interface dmem_resp_if;

    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        stall;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, stall
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, stall
    );

endinterface

// File: rtl/dmem_ram.sv
// Single-port word RAM with byte-enable synchronous write and combinational read.
module dmem_ram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = 10
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    input  logic [3:0]       be,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/dmem_resp.sv
// Data-memory access controller: accepts one request, waits WAIT_CYCLES, then pulses a response.
module dmem_resp
    import riscv_pkg::*;
#(
    parameter int DEPTH_WORDS = DMEM_DEPTH_DEFAULT,
    parameter int WAIT_CYCLES = DMEM_WAIT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    dmem_resp_if.slave  bus
);

    localparam int              IDX_W       = dmem_idx_width(DEPTH_WORDS);
    localparam logic [31:0]     DEPTH_LIMIT = 32'(DEPTH_WORDS);
    localparam logic [3:0]      WAIT_INIT   = 4'(WAIT_CYCLES - 1);

    dmem_state_t state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic        accept;
    logic        enter_resp;
    logic        acc_we;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [3:0]  acc_be;
    logic        acc_err;
    logic        ram_we;
    logic [31:0] ram_rdata;

    assign accept = (state_q == IDLE) && bus.req_valid;

    // With zero wait states RESP is entered straight from IDLE, before the fields are latched.
    always_comb begin
        acc_we    = (state_q == IDLE) ? bus.req_we    : we_q;
        acc_addr  = (state_q == IDLE) ? bus.req_addr  : addr_q;
        acc_wdata = (state_q == IDLE) ? bus.req_wdata : wdata_q;
        acc_be    = (state_q == IDLE) ? bus.req_be    : be_q;
        acc_err   = (acc_addr[1:0] != 2'b00) ||
                    ({2'b00, acc_addr[31:2]} >= DEPTH_LIMIT);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        we_d        = accept ? bus.req_we    : we_q;
        addr_d      = accept ? bus.req_addr  : addr_q;
        wdata_d     = accept ? bus.req_wdata : wdata_q;
        be_d        = accept ? bus.req_be    : be_q;
        rsp_rdata_d = 32'h0;
        rsp_err_d   = 1'b0;
        if (enter_resp) begin
            rsp_err_d   = acc_err;
            rsp_rdata_d = (acc_err || acc_we) ? 32'h0 : ram_rdata;
        end
    end

    assign ram_we = enter_resp && acc_we && !acc_err;

    dmem_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .idx   (acc_addr[IDX_W+1:2]),
        .wdata (acc_wdata),
        .be    (acc_be),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            be_q        <= 4'h0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Stall drops in RESP so the pipeline advances together with the response.
    always_comb begin
        bus.req_ready = (state_q == IDLE);
        bus.rsp_valid = (state_q == RESP);
        bus.stall     = ((state_q == IDLE) && bus.req_valid) || (state_q == WAIT);
        bus.rsp_rdata = rsp_rdata_q;
        bus.rsp_err   = rsp_err_q;
    end

endmodule

// File: tb/tb_dmem_resp.sv
// Directed self-checking bench for dmem_resp at WAIT_CYCLES=2 (dut_a) and WAIT_CYCLES=0 (dut_b).
module tb_dmem_resp;

    logic clk;
    logic reset;
    int   compared;
    int   mismatched;

    dmem_resp_if a_if();
    dmem_resp_if b_if();

    dmem_resp #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (a_if.slave)
    );

    dmem_resp #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (b_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one access on dut_a from IDLE, holding req_valid until rsp_valid; reports latency and response.
    task automatic run_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] be, output int lat, output logic [31:0] rdata,
                              output logic err, output logic hs_ok);
        hs_ok = 1'b1;
        lat   = 999;
        rdata = 32'h0;
        err   = 1'b0;
        a_if.req_we    = we;
        a_if.req_addr  = addr;
        a_if.req_wdata = wdata;
        a_if.req_be    = be;
        a_if.req_valid = 1'b1;
        #1;
        if (!(a_if.stall && a_if.req_ready)) hs_ok = 1'b0;
        @(posedge clk); #1;
        for (int c = 1; c <= 20; c++) begin
            if (a_if.rsp_valid) begin
                lat   = c;
                rdata = a_if.rsp_rdata;
                err   = a_if.rsp_err;
                if (a_if.stall || a_if.req_ready) hs_ok = 1'b0;
                break;
            end
            if (!a_if.stall || a_if.req_ready) hs_ok = 1'b0;
            @(posedge clk); #1;
        end
        a_if.req_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        a_if.req_valid = 1'b0; a_if.req_we = 1'b0; a_if.req_addr = '0; a_if.req_wdata = '0; a_if.req_be = '0;
        b_if.req_valid = 1'b0; b_if.req_we = 1'b0; b_if.req_addr = '0; b_if.req_wdata = '0; b_if.req_be = '0;
        repeat (3) @(posedge clk);
        #1;
        compared++;
        if (a_if.rsp_valid !== 1'b0 || a_if.rsp_err !== 1'b0 || a_if.rsp_rdata !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL reset_outputs: valid=%b err=%b rdata=%h, required 0/0/00000000",
                     a_if.rsp_valid, a_if.rsp_err, a_if.rsp_rdata);
        end
        reset = 1'b0;
        #1;
        compared++;
        if (a_if.req_ready !== 1'b1 || a_if.stall !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_idle: ready=%b stall=%b, required 1/0", a_if.req_ready, a_if.stall);
        end
        a_if.req_valid = 1'b1;
        #1;
        compared++;
        if (a_if.stall !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL reset_stall_follows_valid: stall=%b, required 1", a_if.stall);
        end
        a_if.req_valid = 1'b0;
        #1;
        compared++;
        if (b_if.req_ready !== 1'b1 || b_if.rsp_valid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_dut_b: ready=%b valid=%b, required 1/0", b_if.req_ready, b_if.rsp_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_store_load();
        int lat; logic [31:0] rd; logic er; logic ok;
        run_access(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat, rd, er, ok);
        compared++;
        if (lat !== 3 || rd !== 32'h0 || er !== 1'b0 || ok !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL store_0x10: lat=%0d rdata=%h err=%b hs=%b, required 3/00000000/0/1", lat, rd, er, ok);
        end
        run_access(1'b0, 32'h10, 32'h0, 4'h0, lat, rd, er, ok);
        compared++;
        if (lat !== 3 || rd !== 32'hDEADBEEF || er !== 1'b0 || ok !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL load_0x10: lat=%0d rdata=%h err=%b hs=%b, required 3/deadbeef/0/1", lat, rd, er, ok);
        end
    endtask

    task automatic test_byte_enable();
        int lat; logic [31:0] rd; logic er; logic ok;
        run_access(1'b1, 32'h20, 32'h11223344, 4'hF, lat, rd, er, ok);
        run_access(1'b1, 32'h20, 32'hAABBCCDD, 4'h3, lat, rd, er, ok);
        run_access(1'b0, 32'h20, 32'h0, 4'h0, lat, rd, er, ok);
        compared++;
        if (rd !== 32'h1122CCDD || er !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL byte_enable_0x20: rdata=%h err=%b, required 1122ccdd/0", rd, er);
        end
    endtask

    task automatic test_errors();
        int lat; logic [31:0] rd; logic er; logic ok;
        run_access(1'b0, 32'h22, 32'h0, 4'h0, lat, rd, er, ok);
        compared++;
        if (er !== 1'b1 || rd !== 32'h0 || lat !== 3) begin
            mismatched++;
            $display("[TB] FAIL load_misaligned_0x22: err=%b rdata=%h lat=%0d, required 1/00000000/3", er, rd, lat);
        end
        run_access(1'b0, 32'h1000, 32'h0, 4'h0, lat, rd, er, ok);
        compared++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL load_range_0x1000: err=%b rdata=%h, required 1/00000000", er, rd);
        end
        run_access(1'b0, 32'hFFC, 32'h0, 4'h0, lat, rd, er, ok);
        compared++;
        if (er !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL load_last_word_0xffc: err=%b, required 0", er);
        end
        run_access(1'b1, 32'h12, 32'h0, 4'hF, lat, rd, er, ok);
        compared++;
        if (er !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL store_misaligned_0x12: err=%b, required 1", er);
        end
        run_access(1'b1, 32'h1010, 32'h0, 4'hF, lat, rd, er, ok);
        compared++;
        if (er !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL store_range_0x1010: err=%b, required 1", er);
        end
        run_access(1'b0, 32'h10, 32'h0, 4'h0, lat, rd, er, ok);
        compared++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL error_store_no_write: rdata=%h err=%b, required deadbeef/0", rd, er);
        end
    endtask

    task automatic test_reset_in_wait();
        int lat; logic [31:0] rd; logic er; logic ok;
        int seen;
        run_access(1'b1, 32'h30, 32'h0, 4'hF, lat, rd, er, ok);
        a_if.req_we    = 1'b1;
        a_if.req_addr  = 32'h30;
        a_if.req_wdata = 32'hCAFEF00D;
        a_if.req_be    = 4'hF;
        a_if.req_valid = 1'b1;
        @(posedge clk); #1;
        compared++;
        if (a_if.stall !== 1'b1 || a_if.req_ready !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL wait_before_reset: stall=%b ready=%b, required 1/0", a_if.stall, a_if.req_ready);
        end
        reset = 1'b1;
        #1;
        compared++;
        if (a_if.req_ready !== 1'b1 || a_if.rsp_valid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL async_reset_in_wait: ready=%b valid=%b, required 1/0", a_if.req_ready, a_if.rsp_valid);
        end
        a_if.req_valid = 1'b0;
        seen = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (a_if.rsp_valid) seen++;
        end
        reset = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (a_if.rsp_valid) seen++;
        end
        compared++;
        if (seen !== 0) begin
            mismatched++;
            $display("[TB] FAIL aborted_no_response: rsp_valid pulses=%0d, required 0", seen);
        end
        run_access(1'b0, 32'h30, 32'h0, 4'h0, lat, rd, er, ok);
        compared++;
        if (rd !== 32'h0 || er !== 1'b0 || lat !== 3) begin
            mismatched++;
            $display("[TB] FAIL aborted_no_write_0x30: rdata=%h err=%b lat=%0d, required 00000000/0/3", rd, er, lat);
        end
    endtask

    task automatic test_back_to_back();
        int accepts; int rsps; int consec; int bad_gap; int bad_data;
        int last_acc; logic prev_rsp;
        accepts = 0; rsps = 0; consec = 0; bad_gap = 0; bad_data = 0;
        last_acc = -1; prev_rsp = 1'b0;
        a_if.req_we    = 1'b0;
        a_if.req_addr  = 32'h10;
        a_if.req_wdata = 32'h0;
        a_if.req_be    = 4'h0;
        a_if.req_valid = 1'b1;
        #1;
        for (int i = 0; i < 16; i++) begin
            if (a_if.req_valid && a_if.req_ready) begin
                if (last_acc >= 0 && (i - last_acc) != 4) bad_gap++;
                last_acc = i;
                accepts++;
            end
            if (a_if.rsp_valid) begin
                rsps++;
                if (prev_rsp) consec++;
                if (a_if.rsp_rdata !== 32'hDEADBEEF) bad_data++;
            end
            prev_rsp = a_if.rsp_valid;
            @(posedge clk); #1;
        end
        a_if.req_valid = 1'b0;
        compared++;
        if (accepts !== 4 || bad_gap !== 0) begin
            mismatched++;
            $display("[TB] FAIL b2b_accepts: accepts=%0d bad_gaps=%0d, required 4/0", accepts, bad_gap);
        end
        compared++;
        if (rsps !== 4 || consec !== 0 || bad_data !== 0) begin
            mismatched++;
            $display("[TB] FAIL b2b_responses: rsps=%0d consecutive=%0d bad_data=%0d, required 4/0/0", rsps, consec, bad_data);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_zero_wait();
        b_if.req_we    = 1'b1;
        b_if.req_addr  = 32'h40;
        b_if.req_wdata = 32'h12345678;
        b_if.req_be    = 4'hF;
        b_if.req_valid = 1'b1;
        #1;
        @(posedge clk); #1;
        compared++;
        if (b_if.rsp_valid !== 1'b1 || b_if.rsp_err !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL zw_store_resp: valid=%b err=%b, required 1/0", b_if.rsp_valid, b_if.rsp_err);
        end
        b_if.req_valid = 1'b0;
        @(posedge clk); #1;
        b_if.req_we    = 1'b0;
        b_if.req_valid = 1'b1;
        #1;
        compared++;
        if (b_if.req_ready !== 1'b1 || b_if.stall !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL zw_load_offer: ready=%b stall=%b, required 1/1", b_if.req_ready, b_if.stall);
        end
        @(posedge clk); #1;
        compared++;
        if (b_if.rsp_valid !== 1'b1 || b_if.req_ready !== 1'b0 || b_if.stall !== 1'b0 ||
            b_if.rsp_rdata !== 32'h12345678) begin
            mismatched++;
            $display("[TB] FAIL zw_load_resp: valid=%b ready=%b stall=%b rdata=%h, required 1/0/0/12345678",
                     b_if.rsp_valid, b_if.req_ready, b_if.stall, b_if.rsp_rdata);
        end
        b_if.req_valid = 1'b0;
        @(posedge clk); #1;
        compared++;
        if (b_if.req_ready !== 1'b1 || b_if.rsp_valid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL zw_back_to_idle: ready=%b valid=%b, required 1/0", b_if.req_ready, b_if.rsp_valid);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        test_reset();
        test_store_load();
        test_byte_enable();
        test_errors();
        test_reset_in_wait();
        test_back_to_back();
        test_zero_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
